sub_pipe: RTL

Two-stage pipelined two's-complement subtractor with borrow-in/borrow-out and signed overflow, built from the 4-bit carry-lookahead group logic used by the team's adders. It computes a − b − bin as a + ~b + ~bin: the low half resolves in stage 1, and the registered inter-half carry feeds stage 2. It sits on a valid/ready stream between an operand source and a result consumer, and sustains one operation per clock when not back-pressured.

---
 rtl/sub_pipe.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/sub_pipe.sv
// sub_pipe: two-stage pipelined two's-complement subtractor on a valid/ready
// stream. It computes diff = a - b - bin as a + ~b + ~bin. The low half of the
// sum resolves in stage 1 and the upper half resolves in stage 2, using a
// chain of 4-bit carry-lookahead groups. The inter-half carry is registered
// between the two stages.
//
// Ports:
//   sys_clk    rising-edge clock
//   sys_rst_n  asynchronous active-low reset
//   in_valid   operand beat present
//   in_ready   block accepts an operand beat this cycle
//   a, b       minuend and subtrahend, WIDTH bits
//   bin        borrow-in from a lower-order word
//   out_valid  result beat present
//   out_ready  consumer accepts the result beat this cycle
//   diff       (a - b - bin) mod 2^WIDTH
//   bout       borrow-out: 1 when unsigned a < b + bin
//   ovf        signed overflow of a - b - bin
module sub_pipe #(
   parameter int unsigned WIDTH = 16   // must be a multiple of 8
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   localparam int unsigned HALF = WIDTH / 2;
   localparam int unsigned NGRP = HALF / 4;

   // Pipeline occupancy. Bit 0 is the stage-1 valid flag and bit 1 is the
   // stage-2 valid flag.
   typedef enum logic [1:0] {
      st_empty = 2'b00,
      st_s1    = 2'b01,
      st_s2    = 2'b10,
      st_full  = 2'b11
   } occ_t;

   occ_t occ, occ_nxt;

   // Stage-1 registers
   logic [HALF-1:0] s1_lo;     // low-half difference
   logic            s1_cmid;   // carry out of the low half
   logic [HALF-1:0] s1_ahi;    // upper half of a
   logic [HALF-1:0] s1_nbhi;   // upper half of ~b

   // Handshake signals
   logic v1, v2;
   logic s2_ready;
   logic in_fire, s12_fire, out_fire;

   // Datapath results
   logic [HALF:0]   lo_sum;    // {carry, sum} for the low half
   logic [HALF:0]   hi_sum;    // {carry, sum} for the upper half
   logic [WIDTH-1:0] diff_d;
   logic            bout_d;
   logic            ovf_d;
   logic            a_msb, b_msb;

   // One 4-bit carry-lookahead group. Returns {carry_out, sum[3:0]}.
   function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                       input logic ci);
      logic [3:0] g, p;
      logic [4:0] c;
      g    = x & y;
      p    = x ^ y;
      c[0] = ci;
      c[1] = g[0] | (p[0] & c[0]);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | ((&p) & c[0]);
      return {c[4], p ^ c[3:0]};
   endfunction

   // One half-word adder: the group carries are chained between the
   // 4-bit lookahead groups. Returns {carry_out, sum}.
   function automatic logic [HALF:0] add_half(input logic [HALF-1:0] x,
                                              input logic [HALF-1:0] y,
                                              input logic ci);
      logic [HALF-1:0] s;
      logic [4:0]      r;
      logic            c;
      s = '0;
      c = ci;
      for (int unsigned gi = 0; gi < NGRP; gi++) begin
         r            = cla4(x[gi*4 +: 4], y[gi*4 +: 4], c);
         s[gi*4 +: 4] = r[3:0];
         c            = r[4];
      end
      return {c, s};
   endfunction

   // Ready chain. These signals depend only on the registered state and
   // on out_ready.
   assign v1        = occ[0];
   assign v2        = occ[1];
   assign out_valid = v2;
   assign s2_ready  = !v2 || out_ready;
   assign in_ready  = !v1 || s2_ready;
   assign in_fire   = in_valid && in_ready;
   assign s12_fire  = v1 && s2_ready;
   assign out_fire  = v2 && out_ready;

   // Stage 1 datapath: low half of a + ~b, with carry-in ~bin.
   assign lo_sum = add_half(a[HALF-1:0], ~b[HALF-1:0], ~bin);

   // Stage 2 datapath: upper half, with the registered inter-half carry as
   // carry-in. The operand sign bits are recovered from the registered
   // upper halves. The b sign bit is the inverse of the MSB of ~b.
   assign hi_sum = add_half(s1_ahi, s1_nbhi, s1_cmid);
   assign a_msb  = s1_ahi[HALF-1];
   assign b_msb  = ~s1_nbhi[HALF-1];
   assign diff_d = {hi_sum[HALF-1:0], s1_lo};
   assign bout_d = ~hi_sum[HALF];
   assign ovf_d  = (a_msb != b_msb) && (hi_sum[HALF-1] != a_msb);

   // Next occupancy state. Each valid flag is set by the transfer into its
   // stage. It is cleared by the transfer out of its stage unless that
   // transfer is refilled on the same edge.
   always_comb begin
      logic v1_nxt, v2_nxt;
      v1_nxt  = in_fire  || (v1 && !s12_fire);
      v2_nxt  = s12_fire || (v2 && !out_fire);
      occ_nxt = occ_t'({v2_nxt, v1_nxt});
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         occ     <= st_empty;
         s1_lo   <= '0;
         s1_cmid <= 1'b0;
         s1_ahi  <= '0;
         s1_nbhi <= '0;
         diff    <= '0;
         bout    <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         occ <= occ_nxt;
         if (in_fire) begin
            s1_lo   <= lo_sum[HALF-1:0];
            s1_cmid <= lo_sum[HALF];
            s1_ahi  <= a[WIDTH-1:HALF];
            s1_nbhi <= ~b[WIDTH-1:HALF];
         end
         if (s12_fire) begin
            diff <= diff_d;
            bout <= bout_d;
            ovf  <= ovf_d;
         end
      end
   end

endmodule
